// File: rtl/hyper_ck_diff_monitor.sv
// HyperBus CK/CK# observation monitor: synchronizes the pair, counts CK rising
// edges per programmable window and flags complementarity and stall faults.
//
// state   | meaning
// IDLE    | monitor disabled, window/edge counters held at 0
// ARMED   | enabled, waiting for a CK rise to align the first window
// MEASURE | counting CK rises over back-to-back windows
module hyper_ck_diff_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW_W    = 16,
  parameter int CNT_W       = 16,
  parameter int SKEW_MAX    = 2,
  parameter int STALL_TH    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ck_i,
  input  logic                ck_ni,
  input  logic                en_i,
  input  logic                expect_run_i,
  input  logic [WINDOW_W-1:0] window_i,
  input  logic                clr_i,
  output logic                rise_o,
  output logic                active_o,
  output logic [CNT_W-1:0]    period_cnt_o,
  output logic                period_valid_o,
  output logic                skew_err_o,
  output logic                stall_err_o
);

  localparam int IDLE_W = $clog2(STALL_TH + 1);
  localparam int SKEW_W = $clog2(SKEW_MAX + 2);

  localparam logic [IDLE_W-1:0] IDLE_TH    = IDLE_W'(STALL_TH);
  localparam logic [IDLE_W-1:0] IDLE_TH_M1 = IDLE_W'(STALL_TH - 1);
  localparam logic [SKEW_W-1:0] SKEW_LIM   = SKEW_W'(SKEW_MAX + 1);
  localparam logic [CNT_W-1:0]  EDGE_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE
  } state_t;

  logic [SYNC_STAGES-1:0] r_ck_sync;
  logic [SYNC_STAGES-1:0] r_ckn_sync;
  logic                   r_ck_hist;
  logic                   r_rise;
  logic [IDLE_W-1:0]      r_idle_cnt;
  logic [SKEW_W-1:0]      r_skew_cnt;
  logic                   r_skew_err;
  logic                   r_stall_err;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WINDOW_W-1:0]    r_win_cnt;
  logic [WINDOW_W-1:0]    r_win_len;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic [CNT_W-1:0]       r_period_cnt;
  logic                   r_period_valid;

  logic                   w_ck;
  logic                   w_ckn;
  logic                   w_stall_set;
  logic                   w_skew_set;
  logic                   w_measuring;
  logic                   w_win_done;
  logic                   w_arm;
  logic [WINDOW_W-1:0]    w_win_len_in;
  logic [CNT_W-1:0]       w_edge_sum;

  assign w_ck  = r_ck_sync[SYNC_STAGES-1];
  assign w_ckn = r_ckn_sync[SYNC_STAGES-1];

  // Reset to the gated-idle pattern (CK low, CK# high) so no false edge or skew.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ck_sync  <= '0;
      r_ckn_sync <= '1;
      r_ck_hist  <= 1'b0;
      r_rise     <= 1'b0;
    end else begin
      r_ck_sync  <= {r_ck_sync[SYNC_STAGES-2:0], ck_i};
      r_ckn_sync <= {r_ckn_sync[SYNC_STAGES-2:0], ck_ni};
      r_ck_hist  <= w_ck;
      r_rise     <= w_ck & ~r_ck_hist;
    end
  end

  assign w_stall_set = en_i & expect_run_i & (r_idle_cnt == IDLE_TH_M1) & ~r_rise;
  assign w_skew_set  = (r_skew_cnt == SKEW_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt  <= IDLE_TH;
      r_skew_cnt  <= '0;
      r_skew_err  <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      if (r_rise) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != IDLE_TH) begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end

      if (!en_i || (w_ck != w_ckn)) begin
        r_skew_cnt <= '0;
      end else if (r_skew_cnt != SKEW_LIM) begin
        r_skew_cnt <= r_skew_cnt + SKEW_W'(1);
      end

      // A fault seen in the same cycle as a clear must not be lost.
      if (w_skew_set) begin
        r_skew_err <= 1'b1;
      end else if (clr_i) begin
        r_skew_err <= 1'b0;
      end

      if (w_stall_set) begin
        r_stall_err <= 1'b1;
      end else if (clr_i) begin
        r_stall_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_win_done  = 1'b0;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (r_rise) begin
            w_state_nxt = S_MEASURE;
            w_arm       = 1'b1;
          end
        end
        S_MEASURE: w_win_done = (r_win_cnt == (r_win_len - WINDOW_W'(1)));
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_measuring  = en_i & (r_state == S_MEASURE);
  assign w_win_len_in = (window_i == '0) ? WINDOW_W'(1) : window_i;
  assign w_edge_sum   = (r_edge_cnt == EDGE_MAX) ? r_edge_cnt : (r_edge_cnt + CNT_W'(r_rise));

  // A rise in the closing cycle belongs to the closing window; the next starts at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win_cnt      <= '0;
      r_edge_cnt     <= '0;
      r_win_len      <= WINDOW_W'(1);
      r_period_cnt   <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_win_done;
      if (w_win_done) begin
        r_period_cnt <= w_edge_sum;
      end
      if (w_arm || w_win_done) begin
        r_win_len <= w_win_len_in;
      end
      if (w_measuring && !w_win_done) begin
        r_win_cnt  <= r_win_cnt + WINDOW_W'(1);
        r_edge_cnt <= w_edge_sum;
      end else begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
      end
    end
  end

  assign rise_o         = r_rise;
  assign active_o       = (r_idle_cnt < IDLE_TH);
  assign period_cnt_o   = r_period_cnt;
  assign period_valid_o = r_period_valid;
  assign skew_err_o     = r_skew_err;
  assign stall_err_o    = r_stall_err;

endmodule

// File: tb/tb_hyper_ck_diff_monitor.sv
// Self-checking bench for hyper_ck_diff_monitor: table-driven rate windows with a
// period scoreboard, plus hand sequences for stall, gating, skew, disable/reset, saturation.
`timescale 1ns/1ps
module tb_hyper_ck_diff_monitor;

  logic        clk = 1'b0;
  logic        rst_n, ck_i, ck_ni, en, en_s, expect_run, clr;
  logic [15:0] window, window_s;
  logic        rise_o, active_o, period_valid_o, skew_err_o, stall_err_o;
  logic [15:0] period_cnt_o;
  logic        rise_s, active_s, valid_s, skew_s, stall_s;
  logic [2:0]  period_cnt_s;

  always #5 clk = ~clk;

  hyper_ck_diff_monitor dut (
    .clk_i(clk), .rst_ni(rst_n), .ck_i(ck_i), .ck_ni(ck_ni), .en_i(en),
    .expect_run_i(expect_run), .window_i(window), .clr_i(clr),
    .rise_o(rise_o), .active_o(active_o), .period_cnt_o(period_cnt_o),
    .period_valid_o(period_valid_o), .skew_err_o(skew_err_o), .stall_err_o(stall_err_o)
  );

  hyper_ck_diff_monitor #(.CNT_W(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .ck_i(ck_i), .ck_ni(ck_ni), .en_i(en_s),
    .expect_run_i(expect_run), .window_i(window_s), .clr_i(clr),
    .rise_o(rise_s), .active_o(active_s), .period_cnt_o(period_cnt_s),
    .period_valid_o(valid_s), .skew_err_o(skew_s), .stall_err_o(stall_s)
  );

  typedef struct {
    int per;
    int win;
    int exp_cnt;
    int nwin;
  } rate_vec_t;

  localparam int NVEC = 5;
  rate_vec_t vecs[NVEC];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise = -1;
  int last_valid = -1;
  int rint_exp = 0;
  int vint_exp = 0;
  int ck_per = 8;
  int ck_ph = 0;
  bit ck_run = 1'b0;
  bit skew_force = 1'b0;
  bit sb_on = 1'b0;
  int exp_q[$];
  int got, t_act, t_stl, t_arm, t_vs, ones;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One controller cycle: sample outputs on the falling edge, then drive the CK pair.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rise_o) begin
      if (rint_exp != 0 && last_rise >= 0) check("rise_interval", cyc - last_rise, rint_exp);
      last_rise = cyc;
    end
    if (period_valid_o) begin
      if (vint_exp != 0 && last_valid >= 0) check("valid_interval", cyc - last_valid, vint_exp);
      last_valid = cyc;
      if (sb_on) begin
        if (exp_q.size() == 0) check("sb_unexpected_valid", period_valid_o, 0);
        else check("sb_period_cnt", period_cnt_o, exp_q.pop_front());
      end
    end
    if (ck_run) begin
      ck_ph = (ck_ph + 1) % ck_per;
      ck_i  = (ck_ph < ck_per / 2);
    end else begin
      ck_i = 1'b0;
    end
    ck_ni = skew_force ? ck_i : ~ck_i;
  endtask

  task automatic wait_drain(input int bound, input string name);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      check(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_rise(input int bound, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < bound && seen == 0; k++) begin
      step();
      if (rise_o) seen = 1;
    end
    if (seen == 0) check(name, rise_o, 1);
  endtask

  task automatic wait_valid(input int bound, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < bound && seen == 0; k++) begin
      step();
      if (period_valid_o) seen = 1;
    end
    if (seen == 0) check(name, period_valid_o, 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{per: 8,  win: 64, exp_cnt: 8,  nwin: 3};
    vecs[1] = '{per: 4,  win: 32, exp_cnt: 8,  nwin: 2};
    vecs[2] = '{per: 6,  win: 60, exp_cnt: 10, nwin: 2};
    vecs[3] = '{per: 2,  win: 16, exp_cnt: 8,  nwin: 3};
    vecs[4] = '{per: 10, win: 30, exp_cnt: 3,  nwin: 3};

    rst_n = 1'b0; en = 1'b0; en_s = 1'b0; expect_run = 1'b1; clr = 1'b0;
    window = 16'd64; window_s = 16'd200; ck_i = 1'b0; ck_ni = 1'b1;

    repeat (3) step();
    check("rst_rise", rise_o, 0);
    check("rst_active", active_o, 0);
    check("rst_period_cnt", period_cnt_o, 0);
    check("rst_period_valid", period_valid_o, 0);
    check("rst_skew_err", skew_err_o, 0);
    check("rst_stall_err", stall_err_o, 0);
    check("rst_s_rise", rise_s, 0);
    check("rst_s_active", active_s, 0);
    check("rst_s_period_cnt", period_cnt_s, 0);
    check("rst_s_valid", valid_s, 0);
    check("rst_s_skew", skew_s, 0);
    check("rst_s_stall", stall_s, 0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < NVEC; i++) begin
      en = 1'b0; rint_exp = 0; vint_exp = 0; sb_on = 1'b1;
      window = 16'(vecs[i].win); ck_per = vecs[i].per; ck_ph = 0; ck_run = 1'b1;
      repeat (20) step();
      last_rise = -1; last_valid = -1;
      rint_exp = vecs[i].per; vint_exp = vecs[i].win;
      for (int w = 0; w < vecs[i].nwin; w++) exp_q.push_back(vecs[i].exp_cnt);
      en = 1'b1;
      wait_drain((vecs[i].nwin + 2) * vecs[i].win + 40, "rate_window_timeout");
    end

    // Stall detection with the gate expected open.
    en = 1'b0; rint_exp = 0; vint_exp = 0; sb_on = 1'b0;
    ck_per = 8; ck_ph = 0; window = 16'd64;
    repeat (20) step();
    en = 1'b1;
    pulse_clr();
    repeat (40) step();
    check("stall_clear_running", stall_err_o, 0);
    check("active_running", active_o, 1);
    wait_rise(20, "stall_rise_timeout");
    ck_run = 1'b0;
    t_act = -1; t_stl = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (t_act < 0 && !active_o) t_act = cyc;
      if (t_stl < 0 && stall_err_o) t_stl = cyc;
    end
    check("stall_active_fall", t_act - last_rise, 33);
    check("stall_err_latency", t_stl - last_rise, 33);
    ck_run = 1'b1;
    repeat (16) step();
    check("stall_sticky", stall_err_o, 1);
    check("active_resumed", active_o, 1);
    pulse_clr();
    check("stall_clr", stall_err_o, 0);

    // Legal gating: stop the clock with the gate expected closed.
    expect_run = 1'b0;
    wait_rise(20, "gate_rise_timeout");
    ck_run = 1'b0;
    t_act = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (t_act < 0 && !active_o) t_act = cyc;
    end
    check("gate_active_fall", t_act - last_rise, 33);
    check("gate_no_stall", stall_err_o, 0);
    wait_valid(140, "gate_valid_timeout");
    sb_on = 1'b1;
    exp_q.push_back(0);
    wait_drain(140, "gate_zero_window_timeout");
    sb_on = 1'b0;
    expect_run = 1'b1;
    ck_run = 1'b1;
    repeat (20) step();

    // Skew: SKEW_MAX equal cycles are tolerated, one more sets the flag.
    skew_force = 1'b1;
    repeat (2) step();
    skew_force = 1'b0;
    repeat (8) step();
    check("skew_below_limit", skew_err_o, 0);
    skew_force = 1'b1;
    repeat (3) step();
    skew_force = 1'b0;
    repeat (8) step();
    check("skew_at_limit", skew_err_o, 1);
    skew_force = 1'b1;
    repeat (5) step();
    skew_force = 1'b0;
    repeat (30) step();
    check("skew_sticky", skew_err_o, 1);
    pulse_clr();
    check("skew_clr", skew_err_o, 0);
    skew_force = 1'b1;
    repeat (8) step();
    clr = 1'b1;
    step();
    check("skew_set_wins_over_clr", skew_err_o, 1);
    clr = 1'b0;
    repeat (4) step();
    skew_force = 1'b0;
    repeat (8) step();
    check("skew_after_clr_fault", skew_err_o, 1);

    // Disable mid-window: no pulse, count holds, re-arm on the next rise.
    wait_valid(140, "dis_sync_timeout");
    sb_on = 1'b1;
    exp_q.push_back(8);
    wait_drain(140, "dis_first_window_timeout");
    repeat (20) step();
    en = 1'b0;
    repeat (100) step();
    check("disable_hold", period_cnt_o, 8);
    exp_q.push_back(8);
    en = 1'b1;
    t_arm = cyc;
    wait_rise(20, "rearm_rise_timeout");
    t_arm = last_rise;
    wait_drain(100, "rearm_window_timeout");
    check("rearm_window_timing", last_valid - t_arm, 65);

    // Asynchronous reset mid-window.
    repeat (30) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rise", rise_o, 0);
    check("mid_rst_active", active_o, 0);
    check("mid_rst_period_cnt", period_cnt_o, 0);
    check("mid_rst_period_valid", period_valid_o, 0);
    check("mid_rst_skew_err", skew_err_o, 0);
    check("mid_rst_stall_err", stall_err_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (50) step();
    check("post_rst_period_cnt", period_cnt_o, 0);
    sb_on = 1'b0;

    // Edge-count saturation on the narrow-counter instance.
    ck_per = 4; ck_ph = 0;
    repeat (20) step();
    en_s = 1'b1;
    t_vs = 0;
    for (int w = 0; w < 2; w++) begin
      got = 0;
      for (int k = 0; k < 260 && got == 0; k++) begin
        step();
        if (valid_s) got = 1;
      end
      if (got == 0) check("sat_valid_timeout", valid_s, 1);
      else begin
        check("sat_period_cnt", period_cnt_s, 7);
        if (w == 1) check("sat_window_len", cyc - t_vs, 200);
        t_vs = cyc;
      end
    end
    en_s = 1'b0;

    // window_i = 0 behaves as a one-cycle window.
    en = 1'b0;
    window = 16'd0;
    repeat (12) step();
    en = 1'b1;
    wait_valid(20, "win0_arm_timeout");
    ones = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("win0_valid_each_cycle", period_valid_o, 1);
      if (period_cnt_o == 16'd1) ones++;
    end
    check("win0_edge_total", ones, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
